// File: rtl/vecmac_pkg.sv
// Shared types and helpers for the vecmac streaming dot-product engine.
package vecmac_pkg;
  localparam int BUSW = 128;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACC = 1'b1} state_e;

  typedef struct packed {
    logic        ovf;
    logic [63:0] val;
  } sat_t;

  // Clamp an exact sum into the w-bit range of the selected mode.
  function automatic sat_t sat_clamp(input logic signed [63:0] x, input int w, input logic sgn);
    logic signed [63:0] hi, lo;
    sat_t r;
    hi = sgn ? (64'sd1 <<< (w - 1)) - 64'sd1 : (64'sd1 <<< w) - 64'sd1;
    lo = sgn ? -(64'sd1 <<< (w - 1)) : 64'sd0;
    r.ovf = (x > hi) || (x < lo);
    r.val = (x > hi) ? hi : (x < lo) ? lo : x;
    return r;
  endfunction
endpackage

// File: rtl/vecmac_stream_param_if.sv
// Beat input stream and result output stream of vecmac_stream_param.
interface vecmac_stream_param_if #(
  parameter int LANES = 8,
  parameter int ACC_W = 32
);
  import vecmac_pkg::*;
  localparam int NLW = $clog2(LANES) + 1;

  logic            in_valid, in_ready, in_last, in_signed;
  logic [BUSW-1:0] in_a, in_b;
  logic [NLW-1:0]  in_nlanes;
  logic            out_valid, out_ready, out_ovf;
  logic [ACC_W-1:0] out_sum;

  modport master (output in_valid, in_a, in_b, in_last, in_nlanes, in_signed, out_ready,
                  input  in_ready, out_valid, out_sum, out_ovf);
  modport slave  (input  in_valid, in_a, in_b, in_last, in_nlanes, in_signed, out_ready,
                  output in_ready, out_valid, out_sum, out_ovf);
endinterface

// File: rtl/vecmac_res_fifo.sv
// Result FIFO; power-of-2 depth so the pointers wrap naturally.
module vecmac_res_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (count != (AW+1)'(DEPTH));
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/vecmac_stream_param.sv
// Streaming INT8 vector dot-product: products -> tree+accumulate -> result FIFO.
// Define VECMAC_SAT_EN for saturating accumulation with overflow flag.
module vecmac_stream_param
  import vecmac_pkg::*;
#(
  parameter int LANES     = 8,
  parameter int ACC_W     = 32,
  parameter int OUT_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  vecmac_stream_param_if.slave bus
);
  localparam int NLW = $clog2(LANES) + 1;
  localparam int CW  = $clog2(OUT_DEPTH) + 1;

  state_e                  state;
  logic                    first, sgn_cur, sgn_lat, acc_beat, rdy_en;
  logic [LANES-1:0][17:0]  prod_d, prod;
  logic [1:0]              vld_pipe, last_pipe;
  logic                    s1_first, s1_sgn;
  logic [ACC_W-1:0]        acc, acc_nxt;
  logic                    acc_ovf, ovf_nxt;
  logic signed [63:0]      beat_sum, exact;
  logic [ACC_W:0]          fifo_dout;
  logic                    fifo_empty;
  logic [CW-1:0]           occ;
  logic [CW:0]             pend;
  logic                    unused_in, unused_x;

  assign first    = (state == ST_IDLE);
  assign sgn_cur  = first ? bus.in_signed : sgn_lat;
  assign acc_beat = bus.in_valid && bus.in_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [8:0] ea, eb;
    logic              on;
    assign ea = {sgn_cur & bus.in_a[8*i+7], bus.in_a[8*i +: 8]};
    assign eb = {sgn_cur & bus.in_b[8*i+7], bus.in_b[8*i +: 8]};
    assign on = !bus.in_last || (NLW'(i) < bus.in_nlanes);
    assign prod_d[i] = on ? 18'(ea * eb) : '0;
  end

  if (LANES < 16) begin : g_unused
    assign unused_in = ^{bus.in_a[BUSW-1:8*LANES], bus.in_b[BUSW-1:8*LANES]};
  end else begin : g_full
    assign unused_in = 1'b0;
  end

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < LANES; i++) beat_sum += 64'(signed'(prod[i]));
  end

  // acc is always in range for its mode, so extending it gives the exact running sum.
`ifdef VECMAC_SAT_EN
  sat_t sat;
  always_comb begin
    exact = (s1_first ? 64'sd0 : $signed({{(64-ACC_W){s1_sgn & acc[ACC_W-1]}}, acc})) + beat_sum;
    sat   = sat_clamp(exact, ACC_W, s1_sgn);
    if (!s1_first && acc_ovf) begin
      acc_nxt = acc;
      ovf_nxt = 1'b1;
    end else begin
      acc_nxt = sat.val[ACC_W-1:0];
      ovf_nxt = sat.ovf;
    end
  end
  assign unused_x    = ^{exact[63:ACC_W], sat.val[63:ACC_W]};
  assign bus.out_ovf = bus.out_valid & fifo_dout[ACC_W];
`else
  always_comb begin
    exact   = (s1_first ? 64'sd0 : $signed({{(64-ACC_W){s1_sgn & acc[ACC_W-1]}}, acc})) + beat_sum;
    acc_nxt = exact[ACC_W-1:0];
    ovf_nxt = 1'b0;
  end
  assign unused_x    = ^{exact[63:ACC_W], fifo_dout[ACC_W]};
  assign bus.out_ovf = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= ST_IDLE;
      sgn_lat   <= 1'b0;
      rdy_en    <= 1'b0;
      prod      <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
      s1_first  <= 1'b0;
      s1_sgn    <= 1'b0;
      acc       <= '0;
      acc_ovf   <= 1'b0;
    end else begin
      rdy_en    <= 1'b1;
      vld_pipe  <= {vld_pipe[0], acc_beat};
      last_pipe <= {last_pipe[0], acc_beat & bus.in_last};
      if (acc_beat) begin
        prod     <= prod_d;
        s1_first <= first;
        s1_sgn   <= sgn_cur;
        sgn_lat  <= sgn_cur;
        state    <= bus.in_last ? ST_IDLE : ST_ACC;
      end
      if (vld_pipe[0]) begin
        acc     <= acc_nxt;
        acc_ovf <= ovf_nxt;
      end
    end

  // Results still in the pipe count against FIFO space so none can be dropped.
  assign pend = (CW+1)'(occ) + (CW+1)'(last_pipe[0]) + (CW+1)'(vld_pipe[1] & last_pipe[1]);
  assign bus.in_ready = rdy_en && (pend < (CW+1)'(OUT_DEPTH));

  vecmac_res_fifo #(.W(ACC_W + 1), .DEPTH(OUT_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_pipe[1] & last_pipe[1]),
    .din   ({acc_ovf, acc}),
    .pop   (bus.out_valid & bus.out_ready),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (occ)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_sum   = bus.out_valid ? fifo_dout[ACC_W-1:0] : '0;
endmodule

// File: tb/tb_vecmac_stream_param.sv
// Directed bench: four configurations share one stimulus bus, selected by sel.
module tb_vecmac_stream_param;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic         vld = 1'b0, last = 1'b0, sgn = 1'b0, ordy = 1'b0;
  logic [127:0] a = '0, b = '0;
  logic [4:0]   nl = '0;
  int           sel = 0;
  int           n_run = 0, n_fail = 0;
  logic         rdy_sel, ov_sel, ovf_sel;
  logic [63:0]  sum_sel;

  localparam logic [127:0] ONES = {16{8'h01}};
  localparam logic [127:0] FFS  = {16{8'hFF}};
  localparam logic [127:0] A80  = {16{8'h80}};
  localparam logic [127:0] B7F  = {16{8'h7F}};
  localparam logic [127:0] L35  = {{11{8'h7F}}, {5{8'h01}}};

  vecmac_stream_param_if #(.LANES(8),  .ACC_W(32)) i8  ();
  vecmac_stream_param_if #(.LANES(4),  .ACC_W(32)) i4  ();
  vecmac_stream_param_if #(.LANES(16), .ACC_W(32)) i16 ();
  vecmac_stream_param_if #(.LANES(16), .ACC_W(16)) iw  ();

  assign i8.in_valid  = vld && sel == 0; assign i8.in_a  = a; assign i8.in_b  = b; assign i8.in_last  = last;
  assign i8.in_signed = sgn; assign i8.in_nlanes = nl[3:0]; assign i8.out_ready = ordy && sel == 0;
  assign i4.in_valid  = vld && sel == 1; assign i4.in_a  = a; assign i4.in_b  = b; assign i4.in_last  = last;
  assign i4.in_signed = sgn; assign i4.in_nlanes = nl[2:0]; assign i4.out_ready = ordy && sel == 1;
  assign i16.in_valid = vld && sel == 2; assign i16.in_a = a; assign i16.in_b = b; assign i16.in_last = last;
  assign i16.in_signed = sgn; assign i16.in_nlanes = nl; assign i16.out_ready = ordy && sel == 2;
  assign iw.in_valid  = vld && sel == 3; assign iw.in_a  = a; assign iw.in_b  = b; assign iw.in_last  = last;
  assign iw.in_signed = sgn; assign iw.in_nlanes = nl; assign iw.out_ready = ordy && sel == 3;

  vecmac_stream_param #(.LANES(8),  .ACC_W(32), .OUT_DEPTH(4)) u8   (.clk(clk), .rst(rst), .bus(i8.slave));
  vecmac_stream_param #(.LANES(4),  .ACC_W(32), .OUT_DEPTH(4)) u4   (.clk(clk), .rst(rst), .bus(i4.slave));
  vecmac_stream_param #(.LANES(16), .ACC_W(32), .OUT_DEPTH(4)) u16  (.clk(clk), .rst(rst), .bus(i16.slave));
  vecmac_stream_param #(.LANES(16), .ACC_W(16), .OUT_DEPTH(2)) u16w (.clk(clk), .rst(rst), .bus(iw.slave));

  always_comb begin
    rdy_sel = 1'b0; ov_sel = 1'b0; sum_sel = '0; ovf_sel = 1'b0;
    case (sel)
      0: begin rdy_sel = i8.in_ready;  ov_sel = i8.out_valid;  sum_sel = 64'(i8.out_sum);  ovf_sel = i8.out_ovf;  end
      1: begin rdy_sel = i4.in_ready;  ov_sel = i4.out_valid;  sum_sel = 64'(i4.out_sum);  ovf_sel = i4.out_ovf;  end
      2: begin rdy_sel = i16.in_ready; ov_sel = i16.out_valid; sum_sel = 64'(i16.out_sum); ovf_sel = i16.out_ovf; end
      default: begin rdy_sel = iw.in_ready; ov_sel = iw.out_valid; sum_sel = 64'(iw.out_sum); ovf_sel = iw.out_ovf; end
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pick(input int k);
    sel = k;
    @(negedge clk);
  endtask

  // Offer one beat from a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [127:0] ta, input logic [127:0] tb2, input logic tl,
                      input logic [4:0] tn, input logic ts, output bit ok);
    ok = 1'b0;
    a = ta; b = tb2; last = tl; nl = tn; sgn = ts; vld = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (rdy_sel) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic put(input string tag, input logic [127:0] ta, input logic [127:0] tb2,
                     input logic tl, input logic [4:0] tn, input logic ts);
    bit ok;
    send(ta, tb2, tl, tn, ts, ok);
    chk({tag, "_acc"}, 64'(ok), 64'd1);
  endtask

  task automatic get(input string tag, input logic [63:0] es, input logic eo);
    int n = 0;
    while (!ov_sel && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_vld"}, 64'(ov_sel), 64'd1);
    chk({tag, "_sum"}, sum_sel, es);
    chk({tag, "_ovf"}, 64'(ovf_sel), 64'(eo));
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
  endtask

  initial begin
    bit ok;
    int nacc;
    repeat (3) @(negedge clk);
    chk("rst_rdy", 64'(rdy_sel), 64'd0);
    chk("rst_vld", 64'(ov_sel), 64'd0);
    chk("rst_sum", sum_sel, 64'd0);
    chk("rst_ovf", 64'(ovf_sel), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", 64'(rdy_sel), 64'd1);

    // 125 beats of 0xFF*0xFF on 8 lanes
    for (int k = 0; k < 124; k++) put("big", FFS, FFS, 1'b0, 5'd0, 1'b0);
    put("big", FFS, FFS, 1'b1, 5'd8, 1'b0);
    get("big", 64'd65025000, 1'b0);

    put("b2b0", ONES, ONES, 1'b1, 5'd8, 1'b0);
    put("b2b1", FFS, ONES, 1'b1, 5'd2, 1'b0);
    get("b2b0", 64'd8, 1'b0);
    get("b2b1", 64'd510, 1'b0);

    put("nl0", FFS, FFS, 1'b1, 5'd0, 1'b1);
    get("nl0", 64'd0, 1'b0);

    // 4 lanes signed, with result latency
    pick(1);
    put("s4", A80, B7F, 1'b1, 5'd4, 1'b1);
    chk("lat1", 64'(ov_sel), 64'd0);
    @(negedge clk);
    chk("lat2", 64'(ov_sel), 64'd0);
    @(negedge clk);
    chk("lat3", 64'(ov_sel), 64'd1);
    get("s4", 64'h0000_0000_FFFF_0200, 1'b0);

    // mode latched on first beat; later in_signed ignored
    put("mode0", FFS, ONES, 1'b0, 5'd0, 1'b1);
    put("mode1", FFS, ONES, 1'b1, 5'd4, 1'b0);
    get("mode", 64'h0000_0000_FFFF_FFF8, 1'b0);

    pick(2);
    put("l16a", ONES, ONES, 1'b0, 5'd0, 1'b0);
    put("l16b", ONES, ONES, 1'b0, 5'd0, 1'b0);
    put("l16c", L35, L35, 1'b1, 5'd5, 1'b0);
    get("l16", 64'd37, 1'b0);

    pick(3);
    put("w16", FFS, FFS, 1'b1, 5'd16, 1'b0);
`ifdef VECMAC_SAT_EN
    get("w16", 64'hFFFF, 1'b1);
`else
    get("w16", 64'hE010, 1'b0);
`endif

    // backpressure: out_ready low, depth 4
    pick(0);
    nacc = 0;
    for (int k = 1; k <= 5; k++) begin
      send(128'(k), 128'd1, 1'b1, 5'd1, 1'b0, ok);
      if (ok) nacc++;
    end
    chk("bp_nacc", 64'(nacc), 64'd4);
    chk("bp_rdy", 64'(rdy_sel), 64'd0);
    for (int k = 1; k <= 4; k++) get("bp", 64'(k), 1'b0);
    put("bp5", 128'd5, 128'd1, 1'b1, 5'd1, 1'b0);
    put("bp6", 128'd6, 128'd1, 1'b1, 5'd1, 1'b0);
    get("bp5", 64'd5, 1'b0);
    get("bp6", 64'd6, 1'b0);

    // reset mid-vector
    for (int k = 0; k < 3; k++) put("rp", FFS, FFS, 1'b0, 5'd0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rmid_vld", 64'(ov_sel), 64'd0);
    chk("rmid_rdy", 64'(rdy_sel), 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rmid_noout", 64'(ov_sel), 64'd0);
    put("rnew", ONES, ONES, 1'b1, 5'd8, 1'b0);
    get("rnew", 64'd8, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/vecmac_stream_param.md
VECMAC_STREAM_PARAM -- requirements
Module: vecmac_stream_param

Interface
REQ-001 SHALL have parameter LANES, default 8: active INT8 lanes per beat; legal values are 1, 4, 8 and 16.
REQ-002 SHALL have parameter ACC_W, default 32: accumulator/result width; legal range is 16..48.
REQ-003 SHALL have parameter OUT_DEPTH, default 4: result FIFO entries; legal values are powers of 2 from 2 to 16.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous reset, active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: a beat is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the beat is accepted when in_valid and in_ready are both high.
REQ-008 SHALL have ports in_a and in_b, input, 128 bits each: INT8 operands; lane i occupies bits [8i+7:8i]; only lanes 0..LANES-1 are used.
REQ-009 SHALL have port in_last, input, 1 bit: the beat is the final beat of its vector.
REQ-010 SHALL have port in_nlanes, input, clog2(LANES)+1 bits: the number of valid lanes on a last beat (0..LANES); the port is ignored on beats that are not last.
REQ-011 SHALL have port in_signed, input, 1 bit: selects two's-complement (1) or unsigned (0) operands; the value is sampled on the first beat of each vector.
REQ-012 SHALL have port out_valid, output, 1 bit: a result is available.
REQ-013 SHALL have port out_ready, input, 1 bit: the result is consumed when out_valid and out_ready are both high.
REQ-014 SHALL have port out_sum, output, ACC_W bits: the dot product of the vector.
REQ-015 SHALL have port out_ovf, output, 1 bit: the exact sum fell outside the ACC_W range for the mode.

Function
REQ-016 SHALL form per-lane 16-bit products, sign- or zero-extended according to the latched mode; lanes at index >= in_nlanes on a last beat SHALL contribute 0 regardless of their data.
REQ-017 SHALL use a 2-stage pipeline: stage 1 registers the products; stage 2 performs the adder tree plus accumulation; the result is pushed to the FIFO on the edge after stage 2 completes.
REQ-018 SHALL, when the FIFO is empty and out_ready=1, assert out_valid in the 3rd cycle after the clock edge that accepted the last beat.
REQ-019 SHALL implement control FSM states IDLE (no beat of the current vector accepted) and ACC (vector in progress): IDLE->ACC on accepting a non-last beat; ACC->IDLE on accepting a last beat; a last beat accepted in IDLE is a single-beat vector.
REQ-020 SHALL clear the accumulator at the first beat of every vector, and SHALL accept back-to-back vectors with no bubble.
REQ-021 SHALL ignore changes on in_signed while in state ACC.
REQ-022 SHALL hold in_ready=0 while FIFO occupancy plus in-flight results equals OUT_DEPTH, so that no result is ever dropped.
REQ-023 SHALL deliver results in acceptance order; a FIFO push and pop in the same cycle SHALL leave the occupancy unchanged; FIFO pointers SHALL wrap modulo OUT_DEPTH.
REQ-024 SHALL hold out_sum and out_ovf stable while out_valid=1 and out_ready=0.
REQ-025 SHALL produce out_sum=0 and out_ovf=0 for a single-beat vector with in_nlanes=0.

Reset
REQ-026 SHALL, while rst is high, force in_ready=0, out_valid=0, out_sum=0 and out_ovf=0, force the FSM to IDLE, empty the FIFO, and clear the pipeline and accumulator.
REQ-027 SHALL discard a partial vector if rst is asserted mid-vector; the next vector accepted after reset SHALL sum from 0.
REQ-028 SHALL assert in_ready on the first clk edge after rst deasserts.

Configuration
REQ-029 SHALL, when VECMAC_SAT_EN is defined, clamp the accumulator on overflow to 2^(ACC_W-1)-1 or -2^(ACC_W-1) in signed mode, or to 2^ACC_W-1 in unsigned mode; the clamp SHALL persist for the rest of that vector, and out_ovf SHALL be set.
REQ-030 SHALL, when VECMAC_SAT_EN is undefined, wrap the sum modulo 2^ACC_W and tie out_ovf to 0.

Structure
REQ-031 SHALL take BUSW=128, the FSM state enum and the saturation/overflow helper function from the shared package vecmac_pkg.
REQ-032 SHALL implement the result FIFO as the sub-module vecmac_res_fifo, parametrised by width ACC_W+1 and depth OUT_DEPTH.

Verification
REQ-033 SHALL cover: LANES=8, unsigned, 125 beats with all lanes 0xFF x 0xFF, last beat with nlanes=8 -> out_sum=65,025,000, out_ovf=0.
REQ-034 SHALL cover: LANES=4, signed, one last beat with a=0x80, b=0x7F and nlanes=4 -> out_sum=0xFFFF_0200 (-65024).
REQ-035 SHALL cover: LANES=16, all a=b=0x01, 3 beats, last beat nlanes=5 with the upper lanes set to 0x7F -> out_sum=37.
REQ-036 SHALL cover: out_ready=0 while single-beat vectors with sums 1, 2, 3, ... are driven -> in_ready drops once OUT_DEPTH results are pending; after out_ready=1 the results emerge in order with no loss.
REQ-037 SHALL cover: ACC_W=16, LANES=16, unsigned, one beat 0xFF x 0xFF -> with VECMAC_SAT_EN out_sum=0xFFFF and out_ovf=1; without it out_sum=0xE010 and out_ovf=0.
REQ-038 SHALL cover: rst pulse after 3 beats of a vector -> out_valid=0 and no result emitted; the following 1-beat vector of ones with LANES=8 gives out_sum=8.
